legv8_multicycle_core: RTL and testbench



---
 rtl/legv8_multicycle_core.sv | 224 ++++++++++++++++++++++
 tb/tb_legv8_multicycle_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_core.sv
// Multi-cycle LEGv8 subset core (ADD/SUB/AND/ORR, LDUR/STUR, CBZ, B) with internal
// instruction ROM, 31-entry register file, data RAM, sticky halt/illegal and a debug read port.
module legv8_multicycle_core #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] ALUResult,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B} op_t;

  state_t            r_state, w_next_state;
  logic [31:0]       r_ir;
  op_t               r_op, w_dec_op;
  logic              w_dec_bad;
  logic [DATA_W-1:0] r_a, r_b, r_mdr;
  logic [DATA_W-1:0] r_regs [31];
  logic [31:0]       r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  logic [4:0]         w_rn, w_rb_idx, w_wr_idx;
  logic [DATA_W-1:0]  w_rn_data, w_rb_data, w_alu, w_wb_data, w_sext9;
  logic [31:0]        w_pc_plus4, w_cbz_target, w_b_target, w_pc_next;
  logic [IMEM_AW-1:0] w_imem_idx;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic w_ld_ir, w_ld_ops, w_ld_alu, w_ld_mdr, w_reg_we, w_mem_we, w_pc_we;
  logic w_retire, w_set_halt, w_set_ill;

  // Opcode classification of the latched instruction word
  always_comb begin
    w_dec_op  = OP_ADD;
    w_dec_bad = 1'b0;
    if (r_ir[31:26] == 6'b000101) begin
      w_dec_op = OP_B;
    end else if (r_ir[31:24] == 8'hB4) begin
      w_dec_op = OP_CBZ;
    end else begin
      case (r_ir[31:21])
        OPC_ADD:  w_dec_op = OP_ADD;
        OPC_SUB:  w_dec_op = OP_SUB;
        OPC_AND:  w_dec_op = OP_AND;
        OPC_ORR:  w_dec_op = OP_ORR;
        OPC_LDUR: w_dec_op = OP_LDUR;
        OPC_STUR: w_dec_op = OP_STUR;
        default:  w_dec_bad = 1'b1;
      endcase
    end
  end

  // Second read port selects Rm for R-type, Rt otherwise; X31 reads as zero
  assign w_rn      = r_ir[9:5];
  assign w_rb_idx  = (w_dec_op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? r_ir[20:16] : r_ir[4:0];
  assign w_wr_idx  = r_ir[4:0];
  assign w_rn_data = (w_rn == 5'd31) ? '0 : r_regs[w_rn];
  assign w_rb_data = (w_rb_idx == 5'd31) ? '0 : r_regs[w_rb_idx];
  assign dbg_data  = (dbg_addr == 5'd31) ? '0 : r_regs[dbg_addr];

  assign w_sext9      = DATA_W'($signed(r_ir[20:12]));
  assign w_pc_plus4   = pc + 32'd4;
  assign w_cbz_target = pc + (32'($signed(r_ir[23:5])) << 2);
  assign w_b_target   = pc + (32'($signed(r_ir[25:0])) << 2);
  assign w_imem_idx   = pc[IMEM_AW+1:2];
  assign w_dmem_idx   = ALUResult[BYTE_SH +: DMEM_AW];
  assign w_wb_data    = (r_op == OP_LDUR) ? r_mdr : ALUResult;

  always_comb begin
    w_alu = ALUResult;
    case (r_op)
      OP_ADD:           w_alu = r_a + r_b;
      OP_SUB:           w_alu = r_a - r_b;
      OP_AND:           w_alu = r_a & r_b;
      OP_ORR:           w_alu = r_a | r_b;
      OP_LDUR, OP_STUR: w_alu = r_a + w_sext9;
      OP_CBZ:           w_alu = r_b;
      default:          w_alu = ALUResult;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   w_next_state = S_DECODE;
      S_DECODE:  w_next_state = w_dec_bad ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (r_op)
          OP_CBZ:           w_next_state = S_FETCH;
          OP_B:             w_next_state = (w_b_target == pc) ? S_HALT : S_FETCH;
          OP_LDUR, OP_STUR: w_next_state = S_MEM;
          default:          w_next_state = S_WB;
        endcase
      end
      S_MEM:     w_next_state = (r_op == OP_STUR) ? S_FETCH : S_WB;
      S_WB:      w_next_state = S_FETCH;
      default:   w_next_state = S_HALT;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_ld_ir    = 1'b0;
    w_ld_ops   = 1'b0;
    w_ld_alu   = 1'b0;
    w_ld_mdr   = 1'b0;
    w_reg_we   = 1'b0;
    w_mem_we   = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_next  = w_pc_plus4;
    w_retire   = 1'b0;
    w_set_halt = 1'b0;
    w_set_ill  = 1'b0;
    case (r_state)
      S_FETCH:  w_ld_ir = 1'b1;
      S_DECODE: begin
        if (w_dec_bad) begin
          w_set_ill  = 1'b1;
          w_set_halt = 1'b1;
        end else begin
          w_ld_ops = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (r_op)
          OP_CBZ: begin
            w_ld_alu = 1'b1;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            if (r_b == '0) w_pc_next = w_cbz_target;
          end
          OP_B: begin
            w_pc_we    = 1'b1;
            w_retire   = 1'b1;
            w_pc_next  = w_b_target;
            w_set_halt = (w_b_target == pc);
          end
          default: w_ld_alu = 1'b1;
        endcase
      end
      S_MEM: begin
        if (r_op == OP_STUR) begin
          w_mem_we = 1'b1;
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end else begin
          w_ld_mdr = 1'b1;
        end
      end
      S_WB: begin
        w_reg_we = (w_wr_idx != 5'd31);
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      ALUResult <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      r_ir      <= '0;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_mdr     <= '0;
    end else begin
      retire <= w_retire;
      if (w_ld_ir)  r_ir <= r_imem[w_imem_idx];
      if (w_ld_ops) begin
        r_op <= w_dec_op;
        r_a  <= w_rn_data;
        r_b  <= w_rb_data;
      end
      if (w_ld_alu)   ALUResult <= w_alu;
      if (w_ld_mdr)   r_mdr     <= r_dmem[w_dmem_idx];
      if (w_pc_we)    pc        <= w_pc_next;
      if (w_set_halt) halted    <= 1'b1;
      if (w_set_ill)  illegal   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_wr_idx] <= w_wb_data;
    end
  end

  // Data RAM is not cleared by reset; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) r_dmem[w_dmem_idx] <= r_b;
  end

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Bench for legv8_multicycle_core: directed programs plus random programs checked against an
// instruction-level reference model (architectural regs, memory, pc and per-class latency).
module tb_legv8_multicycle_core;

  localparam int unsigned DW     = 64;
  localparam int unsigned IDEPTH = 256;
  localparam int unsigned DDEPTH = 256;
  localparam logic [31:0] HALT_WORD = 32'h1400_0000;
  localparam logic [31:0] BAD_WORD  = 32'hFFFF_FFFF;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] ALUResult;
  logic [31:0]   pc;
  logic          retire, halted, illegal;
  logic [4:0]    dbg_addr = 5'd0;
  logic [DW-1:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int retire_times[$];

  logic [DW-1:0] m_regs [32];
  logic [DW-1:0] m_mem  [DDEPTH];
  logic [31:0]   m_rom  [IDEPTH];
  logic [31:0]   m_pc;
  logic [DW-1:0] m_alu;

  always #5 clk = ~clk;

  legv8_multicycle_core #(
    .DATA_W(DW), .IMEM_DEPTH(IDEPTH), .DMEM_DEPTH(DDEPTH), .IMEM_FILE("program.hex")
  ) dut (
    .clk(clk), .reset(reset), .ALUResult(ALUResult), .pc(pc), .retire(retire),
    .halted(halted), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] a9,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, a9, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
    return {8'hB4, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic longint sext(input logic [25:0] v, input int bits);
    longint x;
    x = longint'(v);
    if (v[bits-1]) x = x - (longint'(1) << bits);
    return x;
  endfunction

  function automatic logic [DW-1:0] rd_reg(input logic [4:0] r);
    return (r == 5'd31) ? '0 : m_regs[r];
  endfunction

  task automatic wr_reg(input logic [4:0] r, input logic [DW-1:0] v);
    if (r != 5'd31) m_regs[r] = v;
  endtask

  // Executes one instruction architecturally; returns its latency and halt/illegal outcome
  task automatic model_step(output int lat, output bit ill, output bit hlt);
    logic [31:0]   ir;
    logic [DW-1:0] va, vb, ea;
    longint        off;
    int            idx;
    ir  = m_rom[(m_pc / 4) % IDEPTH];
    lat = 0; ill = 1'b0; hlt = 1'b0;
    va  = rd_reg(ir[9:5]);
    vb  = rd_reg(ir[4:0]);
    ea  = va + 64'(sext(26'(ir[20:12]), 9));
    idx = int'((ea / 8) % DDEPTH);
    if (ir[31:26] == 6'b000101) begin
      off  = sext(ir[25:0], 26);
      lat  = 3;
      hlt  = (off == 0);
      m_pc = m_pc + 32'(off * 4);
    end else if (ir[31:24] == 8'hB4) begin
      lat   = 3;
      m_alu = vb;
      m_pc  = (vb == 0) ? m_pc + 32'(sext(26'(ir[23:5]), 19) * 4) : m_pc + 32'd4;
    end else begin
      case (ir[31:21])
        OPC_ADD:  m_alu = va + rd_reg(ir[20:16]);
        OPC_SUB:  m_alu = va - rd_reg(ir[20:16]);
        OPC_AND:  m_alu = va & rd_reg(ir[20:16]);
        OPC_ORR:  m_alu = va | rd_reg(ir[20:16]);
        OPC_LDUR: m_alu = ea;
        OPC_STUR: m_alu = ea;
        default:  ill = 1'b1;
      endcase
      if (!ill) begin
        if (ir[31:21] == OPC_LDUR) begin
          lat = 5;
          wr_reg(ir[4:0], m_mem[idx]);
        end else if (ir[31:21] == OPC_STUR) begin
          lat = 4;
          m_mem[idx] = vb;
        end else begin
          lat = 4;
          wr_reg(ir[4:0], m_alu);
        end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic load_rom(input logic [31:0] prog[$]);
    for (int i = 0; i < int'(IDEPTH); i++) begin
      m_rom[i] = (i < prog.size()) ? prog[i] : HALT_WORD;
      dut.r_imem[i] = m_rom[i];
    end
  endtask

  task automatic set_ram(input int idx, input logic [DW-1:0] v);
    m_mem[idx] = v;
    dut.r_dmem[idx] = v;
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < int'(DDEPTH); i++) set_ram(i, {$urandom, $urandom});
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq({name, "_rst_pc"}, 64'(pc), 64'd0);
    check_eq({name, "_rst_alu"}, ALUResult, 64'd0);
    check_eq({name, "_rst_retire"}, 64'(retire), 64'd0);
    check_eq({name, "_rst_halted"}, 64'(halted), 64'd0);
    check_eq({name, "_rst_illegal"}, 64'(illegal), 64'd0);
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_pc  = 32'd0;
    m_alu = '0;
    reset = 1'b0;
  endtask

  task automatic wait_retire(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!retire && cyc < 12);
  endtask

  task automatic read_dbg(input int r, output logic [DW-1:0] v);
    dbg_addr = 5'(r);
    #1;
    v = dbg_data;
  endtask

  task automatic compare_state(input string name);
    logic [DW-1:0] v;
    for (int r = 0; r < 32; r++) begin
      read_dbg(r, v);
      check_eq($sformatf("%s_x%0d", name, r), v, rd_reg(5'(r)));
    end
    for (int i = 0; i < int'(DDEPTH); i++)
      check_eq($sformatf("%s_ram%0d", name, i), dut.r_dmem[i], m_mem[i]);
  endtask

  // Runs the loaded program from reset until halt, checking every retirement
  task automatic run_prog(input string name);
    int lat, cyc, nret, cum;
    bit ill, hlt;
    cum = 0;
    retire_times.delete();
    for (int n = 0; n < 300; n++) begin
      model_step(lat, ill, hlt);
      if (ill) begin
        nret = 0;
        repeat (6) begin
          @(posedge clk);
          #1;
          if (retire) nret++;
        end
        check_eq({name, "_ill_retires"}, 64'(nret), 64'd0);
        check_eq({name, "_ill_halted"}, 64'(halted), 64'd1);
        check_eq({name, "_ill_illegal"}, 64'(illegal), 64'd1);
        check_eq({name, "_ill_pc"}, 64'(pc), 64'(m_pc));
        break;
      end
      wait_retire(cyc);
      cum += cyc;
      retire_times.push_back(cum);
      check_eq($sformatf("%s_lat%0d", name, n), 64'(cyc), 64'(lat));
      if (!retire) break;
      check_eq($sformatf("%s_pc%0d", name, n), 64'(pc), 64'(m_pc));
      check_eq($sformatf("%s_alu%0d", name, n), ALUResult, m_alu);
      if (hlt) begin
        nret = 0;
        repeat (5) begin
          @(posedge clk);
          #1;
          if (retire) nret++;
        end
        check_eq({name, "_halt_halted"}, 64'(halted), 64'd1);
        check_eq({name, "_halt_illegal"}, 64'(illegal), 64'd0);
        check_eq({name, "_halt_pc"}, 64'(pc), 64'(m_pc));
        check_eq({name, "_halt_retires"}, 64'(nret), 64'd0);
        break;
      end
    end
    compare_state(name);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [10:0] rops [4];
    rops[0] = OPC_ADD; rops[1] = OPC_SUB; rops[2] = OPC_AND; rops[3] = OPC_ORR;
    k = int'($urandom_range(0, 18));
    if (k < 8)
      return enc_r(rops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 5'($urandom));
    else if (k < 10)
      return enc_d(OPC_LDUR, 9'($urandom), 5'($urandom), 5'($urandom));
    else if (k < 13)
      return enc_d(OPC_LDUR, 9'(8 * $urandom_range(0, 31)), 5'd31, 5'($urandom));
    else if (k < 15)
      return enc_d(OPC_STUR, 9'($urandom), 5'($urandom), 5'($urandom));
    else if (k < 17)
      return enc_cbz(19'($urandom_range(1, 4)), ($urandom_range(0, 1) == 0) ? 5'd31 : 5'($urandom));
    else
      return enc_b(26'($urandom_range(1, 4)));
  endfunction

  initial begin
    logic [31:0]   prog[$];
    logic [DW-1:0] v;
    int            cyc;

    // Main directed program: load/add/store, SUB wrap, CBZ taken/not taken, ORR, XZR write, B #0
    prog = '{enc_d(OPC_LDUR, 9'd8, 5'd31, 5'd2), enc_r(OPC_ADD, 5'd2, 5'd2, 5'd3),
             enc_d(OPC_STUR, 9'd16, 5'd31, 5'd3), enc_r(OPC_SUB, 5'd2, 5'd31, 5'd4),
             enc_cbz(19'd3, 5'd31), BAD_WORD, BAD_WORD, enc_cbz(19'd5, 5'd2),
             enc_r(OPC_ORR, 5'd3, 5'd2, 5'd5), enc_r(OPC_ADD, 5'd2, 5'd2, 5'd31), enc_b(26'd0)};
    load_rom(prog);
    fill_ram_random();
    set_ram(1, 64'd5);
    do_reset("p1");
    run_prog("p1");
    check_eq("p1_ret0_cycle", 64'(retire_times[0]), 64'd5);
    check_eq("p1_ret1_cycle", 64'(retire_times[1]), 64'd9);
    check_eq("p1_ret2_cycle", 64'(retire_times[2]), 64'd13);
    check_eq("p1_ret4_cycle", 64'(retire_times[4]), 64'd20);
    read_dbg(3, v);  check_eq("p1_x3_const", v, 64'd10);
    read_dbg(4, v);  check_eq("p1_x4_const", v, 64'hFFFF_FFFF_FFFF_FFFB);
    read_dbg(5, v);  check_eq("p1_x5_const", v, 64'hF);
    read_dbg(31, v); check_eq("p1_xzr_const", v, 64'd0);
    check_eq("p1_ram2_const", dut.r_dmem[2], 64'd10);
    check_eq("p1_final_pc", 64'(pc), 64'h28);

    // Reset while LDUR is in MEM, then reset while STUR is in MEM
    prog = '{enc_d(OPC_LDUR, 9'd8, 5'd31, 5'd2), enc_d(OPC_STUR, 9'd24, 5'd31, 5'd2), enc_b(26'd0)};
    load_rom(prog);
    fill_ram_random();
    set_ram(1, 64'd5);
    set_ram(3, 64'h77);
    do_reset("p3");
    dbg_addr = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("p3_ldabort_pc", 64'(pc), 64'd0);
    check_eq("p3_ldabort_retire", 64'(retire), 64'd0);
    check_eq("p3_ldabort_alu", ALUResult, 64'd0);
    check_eq("p3_ldabort_x2", dbg_data, 64'd0);
    reset = 1'b0;
    wait_retire(cyc);
    check_eq("p3_restart_lat", 64'(cyc), 64'd5);
    @(posedge clk);
    #1;
    check_eq("p3_x2_loaded", dbg_data, 64'd5);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("p3_stabort_ram3", dut.r_dmem[3], 64'h77);
    check_eq("p3_stabort_pc", 64'(pc), 64'd0);

    // Illegal encoding after one legal instruction
    prog = '{enc_r(OPC_ADD, 5'd31, 5'd31, 5'd1), BAD_WORD};
    load_rom(prog);
    fill_ram_random();
    do_reset("p2");
    run_prog("p2");

    // Random forward-only programs ending in the B #0 fill
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      for (int i = 0; i < 40; i++) prog.push_back(rand_instr());
      load_rom(prog);
      fill_ram_random();
      do_reset($sformatf("rnd%0d", t));
      run_prog($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
